// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    // Arbiter FSM: idle, waiting on a fetch response, waiting on a data response.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2
    } arb_state_t;

    // Fetches always read a full word.
    localparam logic [3:0] BE_ALL = 4'hF;

    // True while a memory command is outstanding.
    function automatic logic is_wait_state(input arb_state_t s);
        return (s == I_WAIT) || (s == D_WAIT);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of pipeline-side and memory-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding
// pipeline and memory model.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction fetch port
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_flush_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_valid_o;

    // Data load/store port
    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic [3:0]        d_be_i;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_valid_o;

    // Pipeline control
    logic              stall_o;
    logic              timeout_o;

    // Memory command/response
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [3:0]        mem_be_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_valid_i;

    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        output if_rdata_o, if_valid_o,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
        output d_rdata_o, d_valid_o,
        output stall_o, timeout_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        input  mem_rdata_i, mem_valid_i
    );

    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        input  if_rdata_o, if_valid_o,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
        input  d_rdata_o, d_valid_o,
        input  stall_o, timeout_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        output mem_rdata_i, mem_valid_i
    );

endinterface

// File: rtl/mem_arb_timeout.sv
// Wait-cycle counter with a sticky timeout flag. The counter runs while a
// command is outstanding and is cleared whenever the arbiter is idle.
// expire fires in the last allowed wait cycle if no response arrives in it.
module mem_arb_timeout #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic count_en,
    input  logic clr,
    input  logic hit,
    output logic expire,
    output logic timeout
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;
    logic             flag_r;
    logic             expire_s;

    // A response in the final cycle wins over the abort.
    assign expire_s = count_en & ~hit & (cnt_r == CNT_LAST);
    assign expire   = expire_s;
    assign timeout  = flag_r;

    // Wait-cycle counter, zero whenever the arbiter is idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (count_en) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Sticky error flag, only reset can clear it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flag_r <= 1'b0;
        end else if (expire_s) begin
            flag_r <= 1'b1;
        end else begin
            flag_r <= flag_r;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and
// the data stage. Data accesses win in IDLE because they belong to the
// older instruction; a fetch in flight is always allowed to finish first.
// All outputs except stall_o are registered.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    mem_port_arbiter_if.slave    bus
);
    arb_state_t        state_r;
    arb_state_t        state_nxt_s;

    logic              mem_req_r,   mem_req_nxt_s;
    logic              mem_we_r,    mem_we_nxt_s;
    logic [ADDR_W-1:0] mem_addr_r,  mem_addr_nxt_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_nxt_s;
    logic [3:0]        mem_be_r,    mem_be_nxt_s;
    logic              if_valid_r,  if_valid_nxt_s;
    logic [DATA_W-1:0] if_rdata_r,  if_rdata_nxt_s;
    logic              d_valid_r,   d_valid_nxt_s;
    logic [DATA_W-1:0] d_rdata_r,   d_rdata_nxt_s;
    logic              discard_r,   discard_nxt_s;

    logic              d_take_s;
    logic              if_take_s;
    logic              count_en_s;
    logic              clr_s;
    logic              expire_s;
    logic              timeout_s;

    // A request is still pending unless its completion pulse is showing
    // this cycle; the requester drops the level only after seeing it.
    assign d_take_s   = bus.d_req_i & ~d_valid_r;
    assign if_take_s  = bus.if_req_i & ~if_valid_r & ~bus.if_flush_i;

    assign count_en_s = is_wait_state(state_r);
    assign clr_s      = ~count_en_s;

    mem_arb_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .count_en (count_en_s),
        .clr      (clr_s),
        .hit      (bus.mem_valid_i),
        .expire   (expire_s),
        .timeout  (timeout_s)
    );

    // Next-state and next-output logic for the arbiter FSM.
    always_comb begin
        state_nxt_s     = state_r;
        mem_req_nxt_s   = 1'b0;
        mem_we_nxt_s    = mem_we_r;
        mem_addr_nxt_s  = mem_addr_r;
        mem_wdata_nxt_s = mem_wdata_r;
        mem_be_nxt_s    = mem_be_r;
        if_valid_nxt_s  = 1'b0;
        if_rdata_nxt_s  = if_rdata_r;
        d_valid_nxt_s   = 1'b0;
        d_rdata_nxt_s   = d_rdata_r;
        discard_nxt_s   = discard_r;

        case (state_r)
            IDLE: begin
                discard_nxt_s = 1'b0;
                if (d_take_s) begin
                    mem_req_nxt_s   = 1'b1;
                    mem_we_nxt_s    = bus.d_we_i;
                    mem_addr_nxt_s  = bus.d_addr_i;
                    mem_wdata_nxt_s = bus.d_wdata_i;
                    mem_be_nxt_s    = bus.d_be_i;
                    state_nxt_s     = D_WAIT;
                end else if (if_take_s) begin
                    mem_req_nxt_s   = 1'b1;
                    mem_we_nxt_s    = 1'b0;
                    mem_addr_nxt_s  = bus.if_addr_i;
                    mem_be_nxt_s    = BE_ALL;
                    state_nxt_s     = I_WAIT;
                end else begin
                    state_nxt_s     = IDLE;
                end
            end

            I_WAIT: begin
                if (bus.mem_valid_i) begin
                    // A flush in the response cycle still kills the pulse.
                    if_rdata_nxt_s = bus.mem_rdata_i;
                    if_valid_nxt_s = ~(discard_r | bus.if_flush_i);
                    discard_nxt_s  = 1'b0;
                    state_nxt_s    = IDLE;
                end else if (expire_s) begin
                    discard_nxt_s  = 1'b0;
                    state_nxt_s    = IDLE;
                end else if (bus.if_flush_i) begin
                    discard_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s    = I_WAIT;
                end
            end

            D_WAIT: begin
                if (bus.mem_valid_i) begin
                    d_rdata_nxt_s = bus.mem_rdata_i;
                    d_valid_nxt_s = 1'b1;
                    state_nxt_s   = IDLE;
                end else if (expire_s) begin
                    state_nxt_s   = IDLE;
                end else begin
                    state_nxt_s   = D_WAIT;
                end
            end

            default: begin
                discard_nxt_s = 1'b0;
                state_nxt_s   = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            mem_be_r    <= 4'h0;
            if_valid_r  <= 1'b0;
            if_rdata_r  <= {DATA_W{1'b0}};
            d_valid_r   <= 1'b0;
            d_rdata_r   <= {DATA_W{1'b0}};
            discard_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            mem_req_r   <= mem_req_nxt_s;
            mem_we_r    <= mem_we_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_wdata_r <= mem_wdata_nxt_s;
            mem_be_r    <= mem_be_nxt_s;
            if_valid_r  <= if_valid_nxt_s;
            if_rdata_r  <= if_rdata_nxt_s;
            d_valid_r   <= d_valid_nxt_s;
            d_rdata_r   <= d_rdata_nxt_s;
            discard_r   <= discard_nxt_s;
        end
    end

    assign bus.mem_req_o   = mem_req_r;
    assign bus.mem_we_o    = mem_we_r;
    assign bus.mem_addr_o  = mem_addr_r;
    assign bus.mem_wdata_o = mem_wdata_r;
    assign bus.mem_be_o    = mem_be_r;
    assign bus.if_valid_o  = if_valid_r;
    assign bus.if_rdata_o  = if_rdata_r;
    assign bus.d_valid_o   = d_valid_r;
    assign bus.d_rdata_o   = d_rdata_r;
    assign bus.timeout_o   = timeout_s;

    // Whole pipeline freezes while either stage still waits on memory.
    assign bus.stall_o     = d_take_s | if_take_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table for the
// basic transactions, then hand-written timeout and reset sequences.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ifr;
        logic [31:0] ifa;
        logic        ifl;
        logic        dr;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [3:0]  dbe;
        logic        mv;
        logic [31:0] mrd;
        logic        e_stall;
        logic        e_mreq;
        logic        e_mwe;
        logic [31:0] e_maddr;
        logic [3:0]  e_mbe;
        logic [31:0] e_mwd;
        logic        e_ivld;
        logic [31:0] e_ird;
        logic        e_dvld;
        logic [31:0] e_drd;
        logic        e_tmo;
    } vec_t;

    localparam int NVEC = 26;
    vec_t tbl [NVEC];

    function automatic vec_t mk(
        input logic ifr, input logic [31:0] ifa, input logic ifl,
        input logic dr, input logic dwe, input logic [31:0] da,
        input logic [31:0] dwd, input logic [3:0] dbe,
        input logic mv, input logic [31:0] mrd,
        input logic st, input logic mq, input logic mw, input logic [31:0] ma,
        input logic [3:0] mb, input logic [31:0] mwd,
        input logic iv, input logic [31:0] ird,
        input logic dv, input logic [31:0] drd, input logic tmo);
        vec_t v;
        v.ifr = ifr; v.ifa = ifa; v.ifl = ifl;
        v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd; v.dbe = dbe;
        v.mv = mv; v.mrd = mrd;
        v.e_stall = st; v.e_mreq = mq; v.e_mwe = mw; v.e_maddr = ma;
        v.e_mbe = mb; v.e_mwd = mwd; v.e_ivld = iv; v.e_ird = ird;
        v.e_dvld = dv; v.e_drd = drd; v.e_tmo = tmo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.if_req_i    = 1'b0;
        bus.if_addr_i   = 32'h0;
        bus.if_flush_i  = 1'b0;
        bus.d_req_i     = 1'b0;
        bus.d_we_i      = 1'b0;
        bus.d_addr_i    = 32'h0;
        bus.d_wdata_i   = 32'h0;
        bus.d_be_i      = 4'h0;
        bus.mem_valid_i = 1'b0;
        bus.mem_rdata_i = 32'h0;
    endtask

    task automatic drive(input vec_t v);
        bus.if_req_i    = v.ifr;
        bus.if_addr_i   = v.ifa;
        bus.if_flush_i  = v.ifl;
        bus.d_req_i     = v.dr;
        bus.d_we_i      = v.dwe;
        bus.d_addr_i    = v.da;
        bus.d_wdata_i   = v.dwd;
        bus.d_be_i      = v.dbe;
        bus.mem_valid_i = v.mv;
        bus.mem_rdata_i = v.mrd;
    endtask

    task automatic check_row(input vec_t v, input int i);
        chk($sformatf("r%0d stall", i),     {31'd0, bus.stall_o},     {31'd0, v.e_stall});
        chk($sformatf("r%0d mem_req", i),   {31'd0, bus.mem_req_o},   {31'd0, v.e_mreq});
        chk($sformatf("r%0d mem_we", i),    {31'd0, bus.mem_we_o},    {31'd0, v.e_mwe});
        chk($sformatf("r%0d mem_addr", i),  bus.mem_addr_o,           v.e_maddr);
        chk($sformatf("r%0d mem_be", i),    {28'd0, bus.mem_be_o},    {28'd0, v.e_mbe});
        chk($sformatf("r%0d mem_wdata", i), bus.mem_wdata_o,          v.e_mwd);
        chk($sformatf("r%0d if_valid", i),  {31'd0, bus.if_valid_o},  {31'd0, v.e_ivld});
        chk($sformatf("r%0d if_rdata", i),  bus.if_rdata_o,           v.e_ird);
        chk($sformatf("r%0d d_valid", i),   {31'd0, bus.d_valid_o},   {31'd0, v.e_dvld});
        chk($sformatf("r%0d d_rdata", i),   bus.d_rdata_o,            v.e_drd);
        chk($sformatf("r%0d timeout", i),   {31'd0, bus.timeout_o},   {31'd0, v.e_tmo});
    endtask

    // One clock: through the active edge to the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive_idle();

        //           ifr ifa     ifl dr dwe da      dwd           dbe   mv mrd            | st mq mw maddr   mbe   mwdata        iv ird           dv drd          tmo
        tbl[0]  = mk(0, 32'h00, 0, 0, 0, 32'h000, 32'h0,        4'h0, 0, 32'h0,        0, 0, 0, 32'h000, 4'h0, 32'h0,        0, 32'h0,        0, 32'h0,      0);
        tbl[1]  = mk(1, 32'h10, 0, 0, 0, 32'h000, 32'h0,        4'h0, 0, 32'h0,        1, 0, 0, 32'h000, 4'h0, 32'h0,        0, 32'h0,        0, 32'h0,      0);
        tbl[2]  = mk(1, 32'h10, 0, 0, 0, 32'h000, 32'h0,        4'h0, 0, 32'h0,        1, 1, 0, 32'h010, 4'hF, 32'h0,        0, 32'h0,        0, 32'h0,      0);
        tbl[3]  = mk(1, 32'h10, 0, 0, 0, 32'h000, 32'h0,        4'h0, 1, 32'h00500093, 1, 0, 0, 32'h010, 4'hF, 32'h0,        0, 32'h0,        0, 32'h0,      0);
        tbl[4]  = mk(1, 32'h10, 0, 0, 0, 32'h000, 32'h0,        4'h0, 0, 32'h0,        0, 0, 0, 32'h010, 4'hF, 32'h0,        1, 32'h00500093, 0, 32'h0,      0);
        tbl[5]  = mk(1, 32'h20, 0, 1, 1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 32'h0,        1, 0, 0, 32'h010, 4'hF, 32'h0,        0, 32'h00500093, 0, 32'h0,      0);
        tbl[6]  = mk(1, 32'h20, 0, 1, 1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 32'h0,        1, 1, 1, 32'h100, 4'hF, 32'hDEADBEEF, 0, 32'h00500093, 0, 32'h0,      0);
        tbl[7]  = mk(1, 32'h20, 0, 1, 1, 32'h100, 32'hDEADBEEF, 4'hF, 1, 32'h0,        1, 0, 1, 32'h100, 4'hF, 32'hDEADBEEF, 0, 32'h00500093, 0, 32'h0,      0);
        tbl[8]  = mk(1, 32'h20, 0, 1, 1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 32'h0,        1, 0, 1, 32'h100, 4'hF, 32'hDEADBEEF, 0, 32'h00500093, 1, 32'h0,      0);
        tbl[9]  = mk(1, 32'h20, 0, 0, 0, 32'h000, 32'h0,        4'h0, 0, 32'h0,        1, 1, 0, 32'h020, 4'hF, 32'hDEADBEEF, 0, 32'h00500093, 0, 32'h0,      0);
        tbl[10] = mk(1, 32'h20, 0, 0, 0, 32'h000, 32'h0,        4'h0, 1, 32'h00000013, 1, 0, 0, 32'h020, 4'hF, 32'hDEADBEEF, 0, 32'h00500093, 0, 32'h0,      0);
        tbl[11] = mk(1, 32'h20, 0, 0, 0, 32'h000, 32'h0,        4'h0, 0, 32'h0,        0, 0, 0, 32'h020, 4'hF, 32'hDEADBEEF, 1, 32'h00000013, 0, 32'h0,      0);
        tbl[12] = mk(1, 32'h40, 0, 0, 0, 32'h000, 32'h0,        4'h0, 0, 32'h0,        1, 0, 0, 32'h020, 4'hF, 32'hDEADBEEF, 0, 32'h00000013, 0, 32'h0,      0);
        tbl[13] = mk(1, 32'h40, 1, 0, 0, 32'h000, 32'h0,        4'h0, 0, 32'h0,        0, 1, 0, 32'h040, 4'hF, 32'hDEADBEEF, 0, 32'h00000013, 0, 32'h0,      0);
        tbl[14] = mk(1, 32'h80, 0, 0, 0, 32'h000, 32'h0,        4'h0, 1, 32'h12345678, 1, 0, 0, 32'h040, 4'hF, 32'hDEADBEEF, 0, 32'h00000013, 0, 32'h0,      0);
        tbl[15] = mk(1, 32'h80, 0, 0, 0, 32'h000, 32'h0,        4'h0, 0, 32'h0,        1, 0, 0, 32'h040, 4'hF, 32'hDEADBEEF, 0, 32'h12345678, 0, 32'h0,      0);
        tbl[16] = mk(1, 32'h80, 0, 0, 0, 32'h000, 32'h0,        4'h0, 0, 32'h0,        1, 1, 0, 32'h080, 4'hF, 32'hDEADBEEF, 0, 32'h12345678, 0, 32'h0,      0);
        tbl[17] = mk(1, 32'h80, 0, 0, 0, 32'h000, 32'h0,        4'h0, 1, 32'h00A00113, 1, 0, 0, 32'h080, 4'hF, 32'hDEADBEEF, 0, 32'h12345678, 0, 32'h0,      0);
        tbl[18] = mk(0, 32'h80, 0, 0, 0, 32'h000, 32'h0,        4'h0, 0, 32'h0,        0, 0, 0, 32'h080, 4'hF, 32'hDEADBEEF, 1, 32'h00A00113, 0, 32'h0,      0);
        tbl[19] = mk(0, 32'h00, 0, 1, 0, 32'h104, 32'h0,        4'h3, 0, 32'h0,        1, 0, 0, 32'h080, 4'hF, 32'hDEADBEEF, 0, 32'h00A00113, 0, 32'h0,      0);
        tbl[20] = mk(0, 32'h00, 0, 1, 0, 32'h104, 32'h0,        4'h3, 0, 32'h0,        1, 1, 0, 32'h104, 4'h3, 32'h0,        0, 32'h00A00113, 0, 32'h0,      0);
        tbl[21] = mk(0, 32'h00, 0, 1, 0, 32'h104, 32'h0,        4'h3, 1, 32'h0000ABCD, 1, 0, 0, 32'h104, 4'h3, 32'h0,        0, 32'h00A00113, 0, 32'h0,      0);
        tbl[22] = mk(0, 32'h00, 0, 1, 0, 32'h104, 32'h0,        4'h3, 0, 32'h0,        0, 0, 0, 32'h104, 4'h3, 32'h0,        0, 32'h00A00113, 1, 32'h0000ABCD, 0);
        tbl[23] = mk(0, 32'h00, 0, 0, 0, 32'h000, 32'h0,        4'h0, 0, 32'h0,        0, 0, 0, 32'h104, 4'h3, 32'h0,        0, 32'h00A00113, 0, 32'h0000ABCD, 0);
        tbl[24] = mk(0, 32'h00, 0, 0, 0, 32'h000, 32'h0,        4'h0, 1, 32'hFFFFFFFF, 0, 0, 0, 32'h104, 4'h3, 32'h0,        0, 32'h00A00113, 0, 32'h0000ABCD, 0);
        tbl[25] = mk(0, 32'h00, 0, 0, 0, 32'h000, 32'h0,        4'h0, 0, 32'h0,        0, 0, 0, 32'h104, 4'h3, 32'h0,        0, 32'h00A00113, 0, 32'h0000ABCD, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Per-cycle vectors: inputs applied on the falling edge, outputs
        // sampled 1 time unit later.
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i]);
            #1;
            check_row(tbl[i], i);
            tick();
        end

        // Timeout: fetch issued, memory silent for 8 wait cycles.
        drive_idle();
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'hC0;
        #1;
        chk("to stall before issue", {31'd0, bus.stall_o}, 32'd1);
        tick();
        #1;
        chk("to mem_req", {31'd0, bus.mem_req_o}, 32'd1);
        chk("to mem_addr", bus.mem_addr_o, 32'hC0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("to wait%0d timeout", k), {31'd0, bus.timeout_o}, 32'd0);
            chk($sformatf("to wait%0d stall", k), {31'd0, bus.stall_o}, 32'd1);
            tick();
            #1;
        end
        bus.if_req_i = 1'b0;
        #1;
        chk("to flag set", {31'd0, bus.timeout_o}, 32'd1);
        chk("to no if_valid", {31'd0, bus.if_valid_o}, 32'd0);
        chk("to no mem_req", {31'd0, bus.mem_req_o}, 32'd0);
        chk("to stall released", {31'd0, bus.stall_o}, 32'd0);

        // Late response after the abort must be ignored.
        bus.mem_valid_i = 1'b1;
        bus.mem_rdata_i = 32'h00000BAD;
        tick();
        bus.mem_valid_i = 1'b0;
        #1;
        chk("late if_valid", {31'd0, bus.if_valid_o}, 32'd0);
        chk("late d_valid", {31'd0, bus.d_valid_o}, 32'd0);
        chk("late if_rdata", bus.if_rdata_o, 32'h00A00113);
        chk("late timeout sticky", {31'd0, bus.timeout_o}, 32'd1);

        // Arbiter is back in IDLE; minimum-latency fetch afterwards.
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'hC4;
        tick();
        #1;
        chk("post-to mem_req", {31'd0, bus.mem_req_o}, 32'd1);
        chk("post-to mem_addr", bus.mem_addr_o, 32'hC4);
        bus.mem_valid_i = 1'b1;
        bus.mem_rdata_i = 32'h00000077;
        tick();
        bus.mem_valid_i = 1'b0;
        #1;
        chk("minlat if_valid", {31'd0, bus.if_valid_o}, 32'd1);
        chk("minlat if_rdata", bus.if_rdata_o, 32'h00000077);
        chk("minlat timeout sticky", {31'd0, bus.timeout_o}, 32'd1);
        bus.if_req_i = 1'b0;
        tick();
        #1;
        chk("minlat pulse width", {31'd0, bus.if_valid_o}, 32'd0);

        // Reset while a load is outstanding.
        bus.d_req_i   = 1'b1;
        bus.d_we_i    = 1'b0;
        bus.d_addr_i  = 32'h200;
        bus.d_be_i    = 4'hF;
        tick();
        #1;
        chk("rst-seq mem_req", {31'd0, bus.mem_req_o}, 32'd1);
        chk("rst-seq mem_addr", bus.mem_addr_o, 32'h200);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.d_req_i = 1'b0;
        #1;
        chk("rst mem_req",   {31'd0, bus.mem_req_o},  32'd0);
        chk("rst mem_we",    {31'd0, bus.mem_we_o},   32'd0);
        chk("rst mem_addr",  bus.mem_addr_o,          32'h0);
        chk("rst mem_wdata", bus.mem_wdata_o,         32'h0);
        chk("rst mem_be",    {28'd0, bus.mem_be_o},   32'h0);
        chk("rst if_valid",  {31'd0, bus.if_valid_o}, 32'd0);
        chk("rst if_rdata",  bus.if_rdata_o,          32'h0);
        chk("rst d_valid",   {31'd0, bus.d_valid_o},  32'd0);
        chk("rst d_rdata",   bus.d_rdata_o,           32'h0);
        chk("rst timeout",   {31'd0, bus.timeout_o},  32'd0);
        chk("rst stall",     {31'd0, bus.stall_o},    32'd0);
        bus.mem_valid_i = 1'b1;
        bus.mem_rdata_i = 32'h00000055;
        tick();
        bus.mem_valid_i = 1'b0;
        #1;
        chk("post-rst d_valid", {31'd0, bus.d_valid_o}, 32'd0);
        chk("post-rst d_rdata", bus.d_rdata_o, 32'h0);
        chk("post-rst mem_req", {31'd0, bus.mem_req_o}, 32'd0);
        tick();
        #1;
        chk("post-rst quiet", {31'd0, bus.d_valid_o | bus.if_valid_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
